// File: rtl/demux32_route_if.sv
// Handshake bundle for demux32_route: one source port steered to two buffered sink ports.
// The slave modport is the demux itself; the master modport is the surrounding source/sinks.
interface demux32_route_if #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
);
    logic             ctl;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out0_valid;
    logic [WIDTH-1:0] out0_data;
    logic             out0_ready;
    logic [CNTW-1:0]  out0_count;
    logic             out1_valid;
    logic [WIDTH-1:0] out1_data;
    logic             out1_ready;
    logic [CNTW-1:0]  out1_count;

    modport slave (
        input  ctl, in_valid, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out0_count,
        output out1_valid, out1_data, out1_count
    );

    modport master (
        output ctl, in_valid, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out0_count,
        input  out1_valid, out1_data, out1_count
    );
endinterface

// File: rtl/demux32_route.sv
// 1-to-2 demux with a one-entry skid-free buffer per output port and a per-port delivery counter.
// ctl steers only the word accepted in the same cycle; buffered words stay on their port.
module demux32_route #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    demux32_route_if.slave   bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    buf_state_e       st0, st0_nxt;
    buf_state_e       st1, st1_nxt;
    logic [WIDTH-1:0] d0, d1;
    logic [CNTW-1:0]  c0, c1;
    logic             sel_ok, in_xfer, ld0, ld1, dq0, dq1;

    // Readiness looks only at the selected buffer so a stalled sink never blocks the other port.
    always_comb begin
        sel_ok  = bus.ctl ? ((st1 == EMPTY) || bus.out1_ready)
                          : ((st0 == EMPTY) || bus.out0_ready);
        in_xfer = bus.in_valid && sel_ok;
        ld0     = in_xfer && !bus.ctl;
        ld1     = in_xfer &&  bus.ctl;
        dq0     = (st0 == FULL) && bus.out0_ready;
        dq1     = (st1 == FULL) && bus.out1_ready;
    end

    always_comb begin
        st0_nxt = st0;
        st1_nxt = st1;
        unique case (st0)
            EMPTY: if (ld0) st0_nxt = FULL;
            FULL:  if (dq0 && !ld0) st0_nxt = EMPTY;
            default: st0_nxt = EMPTY;
        endcase
        unique case (st1)
            EMPTY: if (ld1) st1_nxt = FULL;
            FULL:  if (dq1 && !ld1) st1_nxt = EMPTY;
            default: st1_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st0 <= EMPTY;
            st1 <= EMPTY;
            d0  <= '0;
            d1  <= '0;
            c0  <= '0;
            c1  <= '0;
        end else begin
            st0 <= st0_nxt;
            st1 <= st1_nxt;
            if (ld0) d0 <= bus.in_data;
            if (ld1) d1 <= bus.in_data;
            if (dq0) c0 <= c0 + CNTW'(1);
            if (dq1) c1 <= c1 + CNTW'(1);
        end
    end

    assign bus.in_ready   = sel_ok;
    assign bus.out0_valid = (st0 == FULL);
    assign bus.out1_valid = (st1 == FULL);
    assign bus.out0_data  = d0;
    assign bus.out1_data  = d1;
    assign bus.out0_count = c0;
    assign bus.out1_count = c1;
endmodule

// File: doc/demux32_route.md
DEMUX32_ROUTE -- requirements
Module: demux32_route

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data word width in bits.
REQ-002 The block SHALL have parameter CNTW, default 16, giving the per-port delivered-word counter width in bits.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port ctl  input  1  destination select sampled with in_data (0 -> port 0, 1 -> port 1).
REQ-006 The block SHALL have port in_valid  input  1  source presents a word.
REQ-007 The block SHALL have port in_data  input  WIDTH  source word.
REQ-008 The block SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-009 The block SHALL have ports out0_valid / out1_valid  output  1  port n holds a word.
REQ-010 The block SHALL have ports out0_data / out1_data  output  WIDTH  port n word, registered.
REQ-011 The block SHALL have ports out0_ready / out1_ready  input  1  sink n consumes the word.
REQ-012 The block SHALL have ports out0_count / out1_count  output  CNTW  words delivered on port n.

Function
REQ-013 Transfers: input when in_valid && in_ready; output n when outn_valid && outn_ready, each on the rising clk edge.
REQ-014 Each output port SHALL hold a one-entry buffer with two states, EMPTY (outn_valid=0) and FULL (outn_valid=1).
REQ-015 in_ready SHALL be combinational: (ctl ? buffer1 : buffer0) is EMPTY, or it is FULL and its outn_ready=1.
REQ-016 in_ready SHALL NOT depend on in_valid or on the state of the non-selected port.
REQ-017 An accepted word SHALL load the selected buffer and appear on outn_data with outn_valid=1 in the next cycle (latency 1).
REQ-018 Buffer transitions: EMPTY->FULL on input transfer; FULL->EMPTY on output transfer with no input transfer; FULL->FULL on simultaneous output and input transfer, data replaced by the new word.
REQ-019 A FULL buffer SHALL hold outn_data stable until its output transfer.
REQ-020 ctl SHALL affect only the cycle in which it is sampled; a word already buffered is never re-steered.
REQ-021 The non-selected port SHALL drain independently in the same cycle as an input transfer to the other port.
REQ-022 A word SHALL never be duplicated, dropped or delivered to the port not selected at acceptance.
REQ-023 Per-port order SHALL be preserved; no ordering guarantee exists between ports.
REQ-024 outn_count SHALL increment by 1 on each output transfer of port n and wrap from 2^CNTW-1 to 0 with no flag.
REQ-025 With in_valid=0, in_data and ctl SHALL be ignored.
REQ-026 Sustained throughput SHALL be one word per cycle when the selected sink holds outn_ready=1.

Reset
REQ-027 When rst_n=0 at a clk edge, both buffers SHALL go EMPTY, out0_valid=out1_valid=0 and out0_count=out1_count=0.
REQ-028 out0_data and out1_data SHALL reset to 0.
REQ-029 Reset SHALL take priority over any concurrent transfer; a word presented in the reset cycle is discarded, and buffered words are lost.
REQ-030 in_ready SHALL follow REQ-015 during reset, so it reads 1 once buffers are EMPTY; the source SHALL NOT treat reset-cycle handshakes as accepted.

Verification
REQ-031 Reset, then in_valid=1, ctl=0, in_data=32'hDEADBEEF, out0_ready=0 -> next cycle out0_valid=1, out0_data=32'hDEADBEEF, out1_valid=0; in_ready=0 while ctl=0, in_ready=1 with ctl=1.
REQ-032 Port 0 FULL with out0_ready=0; present ctl=1, 32'h00000001 -> accepted; next cycle out1_data=32'h00000001, out0_data unchanged.
REQ-033 Port 0 FULL with out0_ready=1 and in_valid=1, ctl=0, 32'hA5A5A5A5 for 4 cycles -> in_ready=1 every cycle, out0_valid stays 1, out0_count advances by 1 per cycle.
REQ-034 Preload out1_count=16'hFFFE via 2^16-2 deliveries, then 2 more deliveries -> out1_count reads 16'hFFFF then 16'h0000.
REQ-035 Both ports FULL, rst_n=0 for 1 cycle while in_valid=1 -> out0_valid=out1_valid=0, counts=0, data=0; the presented word never appears on either port.
REQ-036 Random ctl/valid/ready for 10000 cycles -> scoreboard confirms every word delivered exactly once, on its selected port, in per-port order.
